// File: rtl/display_pkg.sv
// Shared constants and types for the display refresh path.
// Driver register map, power-up word list, FSM states, code-B helper.
package display_pkg;

    localparam logic [7:0] ADDR_DIGIT0     = 8'h01;
    localparam logic [7:0] ADDR_DECODE     = 8'h09;
    localparam logic [7:0] ADDR_INTENSITY  = 8'h0A;
    localparam logic [7:0] ADDR_SCAN_LIMIT = 8'h0B;
    localparam logic [7:0] ADDR_SHUTDOWN   = 8'h0C;
    localparam logic [7:0] ADDR_TEST       = 8'h0F;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [2:0] LAST_INIT_IDX  = 3'd3;
    localparam logic [2:0] LAST_FRAME_IDX = 3'd6;

    // Entry 0 is sent first.
    localparam logic [3:0][15:0] INIT_WORDS = {
        {ADDR_TEST,       8'h00},
        {ADDR_SCAN_LIMIT, 8'h05},
        {ADDR_DECODE,     8'h3F},
        {ADDR_SHUTDOWN,   8'h01}
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCK_LO,
        ST_SCK_HI,
        ST_GAP
    } tx_state_t;

    // Non-decimal nibbles would show garbage glyphs; blank them instead.
    function automatic logic [3:0] code_b(input logic [3:0] bcd);
        return (bcd > 4'd9) ? BLANK_CODE : bcd;
    endfunction

endpackage

// File: rtl/display_refresh_ctrl_if.sv
// Word handshake between the refresh sequencer and the SPI word shifter.
// done marks the final gap cycle of a word; eof marks it for a frame's last word.
interface display_refresh_ctrl_if;

    logic        start;
    logic [15:0] word;
    logic        last;
    logic        done;
    logic        eof;

    modport master (
        output start,
        output word,
        output last,
        input  done,
        input  eof
    );

    modport slave (
        input  start,
        input  word,
        input  last,
        output done,
        output eof
    );

endinterface

// File: rtl/spi_word_tx.sv
// Serialises one 16-bit word MSB first: LOAD, 16 x (low H, high H), GAP H.
// A start seen in the last gap cycle chains the next word with no idle cycle.
module spi_word_tx
    import display_pkg::*;
#(
    parameter int H = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    display_refresh_ctrl_if.slave        link,
    output logic                         cs_n,
    output logic                         sck,
    output logic                         mosi
);

    localparam logic [7:0] H_LAST = 8'(H - 1);

    tx_state_t   state;
    logic [7:0]  cnt;
    logic [3:0]  bits;
    logic [15:0] shreg;
    logic        tag;

    // Word FSM with registered pin outputs and end-of-word flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            bits      <= 4'd0;
            shreg     <= 16'd0;
            tag       <= 1'b0;
            cs_n      <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            link.done <= 1'b0;
            link.eof  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (link.start) begin
                        state <= ST_LOAD;
                        shreg <= {link.word[14:0], 1'b0};
                        mosi  <= link.word[15];
                        tag   <= link.last;
                        bits  <= 4'd0;
                        cs_n  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state <= ST_SCK_LO;
                    cnt   <= H_LAST;
                end
                ST_SCK_LO: begin
                    if (cnt == 8'd0) begin
                        state <= ST_SCK_HI;
                        sck   <= 1'b1;
                        cnt   <= H_LAST;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_SCK_HI: begin
                    if (cnt == 8'd0) begin
                        sck <= 1'b0;
                        cnt <= H_LAST;
                        if (bits == 4'd15) begin
                            state     <= ST_GAP;
                            cs_n      <= 1'b1;
                            mosi      <= 1'b0;
                            link.done <= (H == 1);
                            link.eof  <= (H == 1) && tag;
                        end else begin
                            state <= ST_SCK_LO;
                            bits  <= bits + 4'd1;
                            mosi  <= shreg[15];
                            shreg <= {shreg[14:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == 8'd0) begin
                        link.done <= 1'b0;
                        link.eof  <= 1'b0;
                        if (link.start) begin
                            state <= ST_LOAD;
                            shreg <= {link.word[14:0], 1'b0};
                            mosi  <= link.word[15];
                            tag   <= link.last;
                            bits  <= 4'd0;
                            cs_n  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt       <= cnt - 8'd1;
                        link.done <= (cnt == 8'd1);
                        link.eof  <= (cnt == 8'd1) && tag;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/display_refresh_ctrl.sv
// Sequences the power-up words and 7-word digit frames to the display driver.
// Owns snapshot, pending-request merge and busy; the shifter owns pin timing.
module display_refresh_ctrl
    import display_pkg::*;
#(
    parameter int SCK_HALF_PERIOD = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_refresh_stb,
    input  logic [3:0] i_hours_h_bcd,
    input  logic [3:0] i_hours_l_bcd,
    input  logic [3:0] i_minutes_h_bcd,
    input  logic [3:0] i_minutes_l_bcd,
    input  logic [3:0] i_seconds_h_bcd,
    input  logic [3:0] i_seconds_l_bcd,
    input  logic [5:0] i_dp_segs,
    input  logic [3:0] i_intensity,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_spi_cs_n,
    output logic       o_spi_sck,
    output logic       o_spi_mosi
);

    display_refresh_ctrl_if link ();

    spi_word_tx #(
        .H (SCK_HALF_PERIOD)
    ) u_tx (
        .clk   (i_clk),
        .reset (i_reset),
        .link  (link),
        .cs_n  (o_spi_cs_n),
        .sck   (o_spi_sck),
        .mosi  (o_spi_mosi)
    );

    logic            pending;
    logic            init_req;
    logic            mode;
    logic [2:0]      idx;
    logic [2:0]      idx_next;
    logic [5:0][3:0] digit_q;
    logic [5:0]      dp_q;
    logic [5:0][3:0] digit_in;
    logic            last_word;
    logic            word_end;
    logic            start_init;
    logic            start_idle;
    logic            start_pend;
    logic            start_frame;
    logic            start_next;

    assign digit_in = {
        code_b(i_hours_h_bcd),   code_b(i_hours_l_bcd),
        code_b(i_minutes_h_bcd), code_b(i_minutes_l_bcd),
        code_b(i_seconds_h_bcd), code_b(i_seconds_l_bcd)
    };

    assign idx_next    = idx + 3'd1;
    assign last_word   = mode ? (idx == LAST_FRAME_IDX)
                              : (idx == LAST_INIT_IDX);
    assign word_end    = o_busy && link.done;
    assign start_init  = !o_busy && init_req;
    assign start_idle  = !o_busy && !init_req && i_refresh_stb;
    assign start_next  = word_end && !last_word;
    assign start_pend  = word_end && last_word
                         && (pending || i_refresh_stb);
    assign start_frame = start_idle || start_pend;
    assign link.start  = start_init || start_frame || start_next;
    assign o_done      = link.eof;

    // Select the word handed to the shifter in the cycle it starts.
    always_comb begin
        link.word = 16'd0;
        link.last = 1'b0;
        unique case (1'b1)
            start_init: begin
                link.word = INIT_WORDS[0];
            end
            start_frame: begin
                link.word = {ADDR_INTENSITY, 4'h0, i_intensity};
            end
            start_next && !mode: begin
                link.word = INIT_WORDS[idx_next[1:0]];
            end
            start_next && mode: begin
                link.word = {ADDR_DIGIT0 + {5'd0, idx},
                             dp_q[idx], 3'b000, digit_q[idx]};
                link.last = (idx == 3'd5);
            end
            default: ;
        endcase
    end

    // Sequence state, snapshot capture and request merging.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_busy   <= 1'b0;
            pending  <= 1'b0;
            init_req <= 1'b1;
            mode     <= 1'b0;
            idx      <= 3'd0;
            digit_q  <= '0;
            dp_q     <= 6'd0;
        end else begin
            if (start_init) begin
                o_busy   <= 1'b1;
                init_req <= 1'b0;
                mode     <= 1'b0;
                idx      <= 3'd0;
            end
            if (start_frame) begin
                o_busy  <= 1'b1;
                mode    <= 1'b1;
                idx     <= 3'd0;
                digit_q <= digit_in;
                dp_q    <= i_dp_segs;
            end
            if (start_next) begin
                idx <= idx_next;
            end
            if (word_end && last_word && !start_pend) begin
                o_busy <= 1'b0;
            end
            if (start_pend) begin
                pending <= 1'b0;
            end else if (i_refresh_stb && (o_busy || start_init)) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
